// File: rtl/xpb_window_accum_pkg.sv
// Shared defaults, FSM state encoding and a width helper for the window accumulator.
package xpb_window_accum_pkg;

  localparam int XPB_WORD_W  = 1024;
  localparam int XPB_WIN_W   = 5;
  localparam int XPB_NUM_WIN = 8;
  localparam int XPB_GUARD   = 5;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  // Ceiling log2, never below 1 so index ports always have at least one bit.
  function automatic int xpb_clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/xpb_window_accum_if.sv
// Bundle of operand, table-lookup and result signals for the window accumulator.
interface xpb_window_accum_if
  import xpb_window_accum_pkg::*;
#(
  parameter int WORD_W  = XPB_WORD_W,
  parameter int WIN_W   = XPB_WIN_W,
  parameter int NUM_WIN = XPB_NUM_WIN,
  parameter int GUARD   = XPB_GUARD
) ();

  localparam int ACC_W = WORD_W + GUARD;
  localparam int IDX_W = xpb_clog2(NUM_WIN);
  localparam int HI_W  = NUM_WIN * WIN_W;

  logic              in_valid;
  logic              in_ready;
  logic [HI_W-1:0]   hi_bits;
  logic [WORD_W-1:0] base;
  logic [IDX_W-1:0]  lut_idx;
  logic [WIN_W-1:0]  lut_digit;
  logic [WORD_W-1:0] lut_data;
  logic              out_valid;
  logic              out_ready;
  logic [ACC_W-1:0]  sum_out;
  logic [ACC_W-1:0]  carry_out;

  // Producer / table bank / consumer side.
  modport master (
    output in_valid, hi_bits, base, lut_data, out_ready,
    input  in_ready, lut_idx, lut_digit, out_valid, sum_out, carry_out
  );

  // Accumulator side.
  modport slave (
    input  in_valid, hi_bits, base, lut_data, out_ready,
    output in_ready, lut_idx, lut_digit, out_valid, sum_out, carry_out
  );

endinterface

// File: rtl/xpb_window_accum_csa_3to2.sv
// Combinational 3:2 carry-save compressor; carry word is the majority shifted up one bit.
module csa_3to2 #(
  parameter int W = 8
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic [W-1:0] c,
  output logic [W-1:0] sum,
  output logic [W-1:0] carry
);

  logic [W-1:0] maj;

  assign sum   = a ^ b ^ c;
  assign maj   = (a & b) | (a & c) | (b & c);
  // The bit shifted out of the top is always zero thanks to accumulator headroom.
  assign carry = maj << 1;

endmodule

// File: rtl/xpb_window_accum.sv
// Window-driven reduction front end: walks the upper product windows through the
// registered residue tables and folds each return into a carry-save accumulator.
module xpb_window_accum
  import xpb_window_accum_pkg::*;
#(
  parameter int WORD_W  = XPB_WORD_W,
  parameter int WIN_W   = XPB_WIN_W,
  parameter int NUM_WIN = XPB_NUM_WIN,
  parameter int GUARD   = XPB_GUARD
) (
  input  logic                 clk,
  input  logic                 rst_n,
  xpb_window_accum_if.slave    bus
);

  localparam int ACC_W = WORD_W + GUARD;
  localparam int IDX_W = xpb_clog2(NUM_WIN);
  localparam int HI_W  = NUM_WIN * WIN_W;

  state_t            state, state_nxt;
  logic [IDX_W-1:0]  win_p0;
  logic [HI_W-1:0]   hi_p0;
  logic              vld_p1;
  logic [ACC_W-1:0]  sum_p1, carry_p1;
  logic [ACC_W-1:0]  lut_ext, csa_sum, csa_carry;
  logic              accept, issue, last_win;

  assign accept   = (state == IDLE) && bus.in_valid;
  assign issue    = (state == ISSUE);
  assign last_win = (win_p0 == IDX_W'(NUM_WIN - 1));

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state and handshake/lookup outputs; table address is forced to 0 outside ISSUE.
  always_comb begin
    state_nxt     = state;
    bus.in_ready  = 1'b0;
    bus.out_valid = 1'b0;
    bus.lut_idx   = '0;
    bus.lut_digit = '0;
    unique case (state)
      IDLE: begin
        bus.in_ready = 1'b1;
        if (bus.in_valid) state_nxt = ISSUE;
      end
      ISSUE: begin
        bus.lut_idx   = win_p0;
        bus.lut_digit = hi_p0[WIN_W-1:0];
        if (last_win) state_nxt = DRAIN;
      end
      DRAIN: state_nxt = DONE;
      DONE: begin
        bus.out_valid = 1'b1;
        if (bus.out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Stage 0: window counter and window shifter; current digit always sits in the low bits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      win_p0 <= '0;
      hi_p0  <= '0;
      vld_p1 <= 1'b0;
    end else begin
      vld_p1 <= issue;
      if (accept) begin
        win_p0 <= '0;
        hi_p0  <= bus.hi_bits;
      end else if (issue) begin
        hi_p0 <= hi_p0 >> WIN_W;
        if (!last_win) win_p0 <= win_p0 + IDX_W'(1);
      end
    end
  end

  assign lut_ext = {{GUARD{1'b0}}, bus.lut_data};

  csa_3to2 #(.W(ACC_W)) u_csa (
    .a     (sum_p1),
    .b     (carry_p1),
    .c     (lut_ext),
    .sum   (csa_sum),
    .carry (csa_carry)
  );

  // Stage 1: carry-save accumulator, seeded with the low word and fed one table return per valid cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_p1   <= '0;
      carry_p1 <= '0;
    end else if (accept) begin
      sum_p1   <= {{GUARD{1'b0}}, bus.base};
      carry_p1 <= '0;
    end else if (vld_p1) begin
      sum_p1   <= csa_sum;
      carry_p1 <= csa_carry;
    end
  end

  assign bus.sum_out   = sum_p1;
  assign bus.carry_out = carry_p1;

endmodule
